soc_bus_fabric: RTL and testbench

//  Parametrised single-outstanding bus fabric between two masters (m0 = debug unit, m1 = CPU) and N_SLAVES

---
 rtl/soc_bus_pkg.sv | 22 ++
 rtl/soc_bus_arb.sv | 35 +++
 rtl/soc_bus_fabric.sv | 169 ++++++++++++++++
 tb/tb_soc_bus_fabric.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared definitions for the SoC bus fabric: FSM states, error read data,
// and the region-index helper used by the address decoder.
package soc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } bus_state_t;

  localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

  // Region index = top rgn_bits of an adr_w-bit address.
  function automatic int unsigned rgn_of(input logic [63:0] adr,
                                         input int unsigned adr_w,
                                         input int unsigned rgn_bits);
    logic [63:0] mask;
    mask = (64'd1 << rgn_bits) - 64'd1;
    return 32'((adr >> (adr_w - rgn_bits)) & mask);
  endfunction

endpackage

// File: rtl/soc_bus_arb.sv
// Two-request fixed-priority arbiter (req0 wins) with grant lock.
// The lock is taken when the fabric accepts a request and released by the
// fabric in its response cycle.
module soc_bus_arb (
  input  logic clk,
  input  logic n_reset,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  input  logic i_release,
  output logic o_pick,
  output logic o_gnt
);

  logic r_lock;
  logic r_gnt;

  // Combinational winner: master 1 only when master 0 is not requesting.
  assign o_pick = ~i_req0;
  assign o_gnt  = r_gnt;

  // Grant register and lock; grant is frozen while locked.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_lock <= 1'b0;
      r_gnt  <= 1'b0;
    end else if (i_release) begin
      r_lock <= 1'b0;
    end else if (!r_lock && i_take && (i_req0 || i_req1)) begin
      r_lock <= 1'b1;
      r_gnt  <= ~i_req0;
    end
  end

endmodule

// File: rtl/soc_bus_fabric.sv
// Single-outstanding two-master bus fabric with region decode, per-region
// wait states, m1 write protection and registered read data.
// Optional feature macro: BUS_ERR_EN (error response on unmapped access or
// protected write; otherwise err outputs are tied 0).
module soc_bus_fabric
  import soc_bus_pkg::*;
#(
  parameter int unsigned               ADR_W       = 18,
  parameter int unsigned               RGN_BITS    = 2,
  parameter int unsigned               N_SLAVES    = 3,
  parameter logic [N_SLAVES*4-1:0]     WAIT_STATES = {N_SLAVES{4'd1}},
  parameter logic [N_SLAVES-1:0]       M1_WP_MASK  = N_SLAVES'(4)
) (
  input  logic                         clk,
  input  logic                         n_reset,
  input  logic                         m0_valid,
  input  logic [ADR_W-1:0]             m0_adr,
  input  logic [31:0]                  m0_wdata,
  input  logic [3:0]                   m0_wstrb,
  output logic                         m0_rdy,
  output logic [31:0]                  m0_rdata,
  output logic                         m0_err,
  input  logic                         m1_valid,
  input  logic [ADR_W-1:0]             m1_adr,
  input  logic [31:0]                  m1_wdata,
  input  logic [3:0]                   m1_wstrb,
  output logic                         m1_rdy,
  output logic [31:0]                  m1_rdata,
  output logic                         m1_err,
  output logic [N_SLAVES-1:0]          s_sel,
  output logic [ADR_W-RGN_BITS-1:0]    s_adr,
  output logic [31:0]                  s_wdata,
  output logic [3:0]                   s_wstrb,
  input  logic [N_SLAVES*32-1:0]       s_rdata
);

  bus_state_t                r_state, w_state_nxt;
  logic [RGN_BITS-1:0]       r_rgn;
  logic [3:0]                r_cnt;
  logic [ADR_W-RGN_BITS-1:0] r_adr;
  logic [31:0]               r_wdata;
  logic [3:0]                r_wstrb;
  logic [31:0]               r_rdata;

  logic                      w_pick, w_gnt, w_any;
  logic [ADR_W-1:0]          w_adr;
  logic [31:0]               w_wdata;
  logic [3:0]                w_wstrb;
  logic [31:0]               w_rgn_i;
  logic                      w_mapped, w_wp, w_prot;
  logic [3:0]                w_wait;
  logic [N_SLAVES-1:0]       w_sel;
  logic [31:0]               w_rd;

  soc_bus_arb u_arb (
    .clk       (clk),
    .n_reset   (n_reset),
    .i_req0    (m0_valid),
    .i_req1    (m1_valid),
    .i_take    (r_state == ST_IDLE),
    .i_release (r_state == ST_RESP),
    .o_pick    (w_pick),
    .o_gnt     (w_gnt)
  );

  assign w_any   = m0_valid | m1_valid;
  assign w_adr   = w_pick ? m1_adr   : m0_adr;
  assign w_wdata = w_pick ? m1_wdata : m0_wdata;
  assign w_wstrb = w_pick ? m1_wstrb : m0_wstrb;

  // Decode the winning request: region, wait count, write protection.
  always_comb begin
    w_rgn_i  = rgn_of(64'(w_adr), ADR_W, RGN_BITS);
    w_mapped = (w_rgn_i < N_SLAVES);
    w_wait   = '0;
    w_wp     = 1'b0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (w_rgn_i == i) begin
        w_wait = WAIT_STATES[i*4 +: 4];
        w_wp   = M1_WP_MASK[i];
      end
    end
    w_prot = w_pick && w_wp && (w_wstrb != 4'h0);
  end

  // Slave select and read-data mux for the latched region (0 if unmapped).
  always_comb begin
    w_sel = '0;
    w_rd  = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (32'(r_rgn) == i) begin
        w_sel[i] = (r_state == ST_ACCESS);
        w_rd     = s_rdata[i*32 +: 32];
      end
    end
  end

  // Next-state logic: IDLE -> ACCESS -> RESP -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_any) w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (r_cnt == 4'd0) w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

`ifdef BUS_ERR_EN
  logic r_err;

  // Error flag latched with the request; reported with rdy.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset)                        r_err <= 1'b0;
    else if (r_state == ST_IDLE && w_any) r_err <= ~w_mapped | w_prot;
  end

  assign m0_err = m0_rdy & r_err;
  assign m1_err = m1_rdy & r_err;
`else
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  // Request latch, wait counter and read-data capture.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_rgn   <= '0;
      r_cnt   <= '0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
    end else if (r_state == ST_IDLE && w_any) begin
      r_rgn   <= RGN_BITS'(w_rgn_i);
      r_cnt   <= w_wait;
      r_adr   <= w_adr[ADR_W-RGN_BITS-1:0];
      r_wdata <= w_wdata;
      r_wstrb <= w_prot ? 4'h0 : w_wstrb;
    end else if (r_state == ST_ACCESS) begin
      if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end else begin
`ifdef BUS_ERR_EN
        if (r_err)                 r_rdata <= ERR_RDATA;
        else if (r_wstrb == 4'h0)  r_rdata <= w_rd;
`else
        if (r_wstrb == 4'h0)       r_rdata <= w_rd;
`endif
      end
    end
  end

  assign m0_rdy   = (r_state == ST_RESP) && !w_gnt;
  assign m1_rdy   = (r_state == ST_RESP) &&  w_gnt;
  assign m0_rdata = r_rdata;
  assign m1_rdata = r_rdata;
  assign s_sel    = w_sel;
  assign s_adr    = r_adr;
  assign s_wdata  = r_wdata;
  assign s_wstrb  = r_wstrb;

endmodule

// File: tb/tb_soc_bus_fabric.sv
// Self-checking bench for soc_bus_fabric: directed table, multi-master and
// reset sequences, a second instance for wait-state extremes, and random
// transactions checked against a transaction-level model.
module tb_soc_bus_fabric;

`ifdef BUS_ERR_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic clk = 1'b0;
  logic n_reset;
  always #5 clk = ~clk;

  logic        m0_valid, m1_valid;
  logic [17:0] m0_adr, m1_adr;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_rdy, m1_rdy, m0_err, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [2:0]  s_sel;
  logic [15:0] s_adr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [95:0] s_rdata;

  // second instance: region0 WAIT=15, region1/2 WAIT=0
  logic        v2;
  logic [17:0] a2;
  logic        d2_m0_rdy, d2_m0_err, d2_m1_rdy, d2_m1_err;
  logic [31:0] d2_m0_rdata, d2_m1_rdata, d2_s_wdata;
  logic [2:0]  d2_s_sel;
  logic [15:0] d2_s_adr;
  logic [3:0]  d2_s_wstrb;
  logic [95:0] d2_s_rdata;

  logic [31:0] sw [3];
  initial begin
    sw[0] = 32'h12345678;
    sw[1] = 32'hA5A50001;
    sw[2] = 32'hC0DE0002;
  end

  for (genvar g = 0; g < 3; g++) begin : g_slv
    assign s_rdata[g*32 +: 32]    = s_sel[g]    ? sw[g] : 32'h0;
    assign d2_s_rdata[g*32 +: 32] = d2_s_sel[g] ? sw[g] : 32'h0;
  end

  soc_bus_fabric #(.ADR_W(18), .RGN_BITS(2), .N_SLAVES(3),
                   .WAIT_STATES(12'h151), .M1_WP_MASK(3'b100)) dut (
    .clk(clk), .n_reset(n_reset),
    .m0_valid(m0_valid), .m0_adr(m0_adr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_rdy(m0_rdy), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_valid(m1_valid), .m1_adr(m1_adr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_rdy(m1_rdy), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .s_sel(s_sel), .s_adr(s_adr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_rdata(s_rdata)
  );

  soc_bus_fabric #(.ADR_W(18), .RGN_BITS(2), .N_SLAVES(3),
                   .WAIT_STATES(12'h00F), .M1_WP_MASK(3'b100)) dut2 (
    .clk(clk), .n_reset(n_reset),
    .m0_valid(1'b0), .m0_adr(18'h0), .m0_wdata(32'h0), .m0_wstrb(4'h0),
    .m0_rdy(d2_m0_rdy), .m0_rdata(d2_m0_rdata), .m0_err(d2_m0_err),
    .m1_valid(v2), .m1_adr(a2), .m1_wdata(32'h0), .m1_wstrb(4'h0),
    .m1_rdy(d2_m1_rdy), .m1_rdata(d2_m1_rdata), .m1_err(d2_m1_err),
    .s_sel(d2_s_sel), .s_adr(d2_s_adr), .s_wdata(d2_s_wdata), .s_wstrb(d2_s_wstrb),
    .s_rdata(d2_s_rdata)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit          m;
    logic [17:0] adr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
    int          nsel;
    logic [2:0]  sel;
    logic [3:0]  swstrb;
    bit          chk_rd;
    logic [31:0] rdata;
    logic        err;
  } txn_t;

  // Transaction-level reference: region wait table, protection and error rules.
  function automatic txn_t model(input bit m, input logic [17:0] adr,
                                 input logic [31:0] wd, input logic [3:0] ws);
    txn_t t;
    int ws_tb [3] = '{1, 5, 1};
    int r = int'(adr[17:16]);
    bit mapped = (r < 3);
    bit prot = m && (r == 2) && (ws != 4'h0);
    int ext = mapped ? ws_tb[r] : 0;
    t.m = m; t.adr = adr; t.wdata = wd; t.wstrb = ws;
    t.lat    = ext + 2;
    t.nsel   = mapped ? ext + 1 : 0;
    t.sel    = mapped ? 3'(1 << r) : 3'b000;
    t.swstrb = prot ? 4'h0 : ws;
    t.err    = EE && (!mapped || prot);
    if (t.err) begin
      t.chk_rd = 1'b1; t.rdata = 32'hDEADBEEF;
    end else if (ws == 4'h0) begin
      t.chk_rd = 1'b1; t.rdata = mapped ? sw[r] : 32'h0;
    end else begin
      t.chk_rd = 1'b0; t.rdata = 32'h0;
    end
    return t;
  endfunction

  function automatic txn_t mk(input bit m, input logic [17:0] adr, input logic [31:0] wd,
                              input logic [3:0] ws, input int lat, input int nsel,
                              input logic [2:0] sel, input logic [3:0] sws, input bit chk,
                              input logic [31:0] rd, input logic er);
    txn_t t;
    t.m = m; t.adr = adr; t.wdata = wd; t.wstrb = ws; t.lat = lat; t.nsel = nsel;
    t.sel = sel; t.swstrb = sws; t.chk_rd = chk; t.rdata = rd; t.err = er;
    return t;
  endfunction

  task automatic set_req(input bit m, input logic v, input logic [17:0] adr,
                         input logic [31:0] wd, input logic [3:0] ws);
    if (!m) begin
      m0_valid = v; m0_adr = adr; m0_wdata = wd; m0_wstrb = ws;
    end else begin
      m1_valid = v; m1_adr = adr; m1_wdata = wd; m1_wstrb = ws;
    end
  endtask

  task automatic run(input txn_t t, input string nm, input int drop_at);
    int cyc = 0, nsel = 0;
    bit selbad = 0, stray = 0, got = 0;
    logic [31:0] rd = '0, swd = '0;
    logic er = 1'b0, my_rdy, my_err, ot_rdy, ot_err;
    logic [3:0] sws = '0;
    logic [15:0] sa = '0;
    set_req(t.m, 1'b1, t.adr, t.wdata, t.wstrb);
    while (cyc < 40 && !got) begin
      @(posedge clk); #1; cyc++;
      my_rdy = t.m ? m1_rdy : m0_rdy;  my_err = t.m ? m1_err : m0_err;
      ot_rdy = t.m ? m0_rdy : m1_rdy;  ot_err = t.m ? m0_err : m1_err;
      if (cyc == 1) begin sws = s_wstrb; sa = s_adr; swd = s_wdata; end
      if (s_sel != 3'b000) begin nsel++; if (s_sel != t.sel) selbad = 1; end
      if (ot_rdy || ot_err || (!my_rdy && my_err)) stray = 1;
      if (cyc == drop_at) set_req(t.m, 1'b0, t.adr, t.wdata, t.wstrb);
      if (my_rdy) begin got = 1; rd = t.m ? m1_rdata : m0_rdata; er = my_err; end
    end
    set_req(t.m, 1'b0, t.adr, t.wdata, t.wstrb);
    check({nm, "_latency"}, cyc, t.lat);
    check({nm, "_sel_cycles"}, nsel, t.nsel);
    check({nm, "_sel_value"}, {31'h0, selbad}, 32'h0);
    check({nm, "_s_wstrb"}, {28'h0, sws}, {28'h0, t.swstrb});
    check({nm, "_s_adr"}, {16'h0, sa}, {16'h0, t.adr[15:0]});
    check({nm, "_s_wdata"}, swd, t.wdata);
    check({nm, "_stray"}, {31'h0, stray}, 32'h0);
    check({nm, "_err"}, {31'h0, er}, {31'h0, t.err});
    if (t.chk_rd) check({nm, "_rdata"}, rd, t.rdata);
    @(posedge clk); #1;
    check({nm, "_rdy_pulse"}, {31'h0, m0_rdy | m1_rdy}, 32'h0);
  endtask

  // Both masters, each raising valid at a given cycle; checks rdy cycles and data.
  task automatic pair(input string nm, input logic [17:0] a0, input int d0,
                      input logic [17:0] a1, input int d1, input int e0, input int e1,
                      input logic [31:0] r0, input logic [31:0] r1);
    int cyc = 0, t0 = -1, t1 = -1;
    logic [31:0] c0 = '0, c1 = '0;
    set_req(1'b0, d0 == 0, a0, 32'h0, 4'h0);
    set_req(1'b1, d1 == 0, a1, 32'h0, 4'h0);
    while (cyc < 40 && (t0 < 0 || t1 < 0)) begin
      @(posedge clk); #1; cyc++;
      if (m0_rdy) begin t0 = cyc; c0 = m0_rdata; m0_valid = 1'b0; end
      if (m1_rdy) begin t1 = cyc; c1 = m1_rdata; m1_valid = 1'b0; end
      if (cyc == d0) m0_valid = 1'b1;
      if (cyc == d1) m1_valid = 1'b1;
    end
    m0_valid = 1'b0; m1_valid = 1'b0;
    check({nm, "_m0_rdy_cycle"}, t0, e0);
    check({nm, "_m1_rdy_cycle"}, t1, e1);
    check({nm, "_m0_rdata"}, c0, r0);
    check({nm, "_m1_rdata"}, c1, r1);
    @(posedge clk); #1;
  endtask

  task automatic run2(input string nm, input logic [17:0] adr, input int lat, input int nsel);
    int cyc = 0, ns = 0;
    bit got = 0;
    v2 = 1'b1; a2 = adr;
    while (cyc < 40 && !got) begin
      @(posedge clk); #1; cyc++;
      if (d2_s_sel != 3'b000) ns++;
      if (d2_m1_rdy) got = 1;
    end
    v2 = 1'b0;
    check({nm, "_latency"}, cyc, lat);
    check({nm, "_sel_cycles"}, ns, nsel);
    @(posedge clk); #1;
  endtask

  txn_t tbl [7];
  txn_t tr;

  initial begin
    tbl[0] = mk(1, 18'h00010, 32'h0,        4'h0, 3, 2, 3'b001, 4'h0, 1, 32'h12345678, 1'b0);
    tbl[1] = mk(1, 18'h20004, 32'h11112222, 4'hF, 3, 2, 3'b100, 4'h0, EE,
                EE ? 32'hDEADBEEF : 32'h0, EE);
    tbl[2] = mk(0, 18'h20004, 32'h33334444, 4'hF, 3, 2, 3'b100, 4'hF, 0, 32'h0, 1'b0);
    tbl[3] = mk(1, 18'h30000, 32'h0,        4'h0, 2, 0, 3'b000, 4'h0, 1,
                EE ? 32'hDEADBEEF : 32'h0, EE);
    tbl[4] = mk(1, 18'h10020, 32'h0,        4'h0, 7, 6, 3'b010, 4'h0, 1, 32'hA5A50001, 1'b0);
    tbl[5] = mk(0, 18'h2FFFC, 32'h0,        4'h0, 3, 2, 3'b100, 4'h0, 1, 32'hC0DE0002, 1'b0);
    tbl[6] = mk(1, 18'h00ABC, 32'hCAFEF00D, 4'h3, 3, 2, 3'b001, 4'h3, 0, 32'h0, 1'b0);

    n_reset = 1'b0; v2 = 1'b0; a2 = '0;
    set_req(1'b0, 1'b0, '0, '0, '0);
    set_req(1'b1, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_rdy",   {30'h0, m0_rdy, m1_rdy}, 32'h0);
    check("reset_err",   {30'h0, m0_err, m1_err}, 32'h0);
    check("reset_sel",   {29'h0, s_sel}, 32'h0);
    check("reset_wstrb", {28'h0, s_wstrb}, 32'h0);
    check("reset_rdata", m0_rdata, 32'h0);
    check("reset_adr",   {16'h0, s_adr}, 32'h0);
    check("reset_wdata", s_wdata, 32'h0);
    @(negedge clk); n_reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run(tbl[i], $sformatf("vec%0d", i), 0);

    // simultaneous request: m0 first, m1 after RESP + IDLE turnaround
    pair("prio", 18'h00100, 0, 18'h20200, 0, 3, 7, 32'h12345678, 32'hC0DE0002);
    // m0 arriving during m1 access waits for it, then is served next
    pair("lock", 18'h00040, 2, 18'h10000, 0, 11, 7, 32'h12345678, 32'hA5A50001);

    // master dropping valid early still gets its rdy
    run(model(1'b1, 18'h10008, 32'h0, 4'h0), "drop", 1);

    // wait-state extremes on the second instance
    run2("w15", 18'h00040, 17, 16);
    run2("w0",  18'h10040, 2, 1);

    // asynchronous reset in the middle of an access
    set_req(1'b1, 1'b1, 18'h10010, 32'h55AA55AA, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    check("rst_pre_sel", {29'h0, s_sel}, 32'h2);
    n_reset = 1'b0;
    #1;
    check("rst_mid_sel",   {29'h0, s_sel}, 32'h0);
    check("rst_mid_wstrb", {28'h0, s_wstrb}, 32'h0);
    check("rst_mid_rdy",   {31'h0, m1_rdy}, 32'h0);
    check("rst_mid_wdata", s_wdata, 32'h0);
    set_req(1'b1, 1'b0, 18'h0, 32'h0, 4'h0);
    @(negedge clk); n_reset = 1'b1;
    @(posedge clk); #1;
    run(tbl[0], "post_rst", 0);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] ws;
      ws = ($urandom % 2 == 0) ? 4'h0 : 4'($urandom);
      tr = model(1'($urandom), 18'($urandom), $urandom, ws);
      run(tr, $sformatf("rnd%0d", i), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
